// File: rtl/nn_pkg.sv
// Shared 24.24 fixed-point types, saturation constants and sequencer state encoding.
package nn_pkg;

  localparam int unsigned W_FIX = 48;
  localparam int unsigned FRAC  = 24;

  typedef logic signed [W_FIX-1:0] fix_t;

  localparam fix_t FIX_ONE = 48'sh000001000000;
  localparam fix_t FIX_MAX = 48'sh7FFFFFFFFFFF;
  localparam fix_t FIX_MIN = 48'sh800000000000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    ACT   = 2'd2,
    OUT   = 2'd3
  } nseq_state_e;

endpackage

// File: rtl/neuron_mac.sv
// Combinational multiply-accumulate step: 24.24 product with saturation,
// then a saturating add into the running sum.
module neuron_mac
  import nn_pkg::*;
(
  input  fix_t acc_i,
  input  fix_t x_i,
  input  fix_t w_i,
  output fix_t sum_c,
  output logic sat_c
);

  localparam int unsigned PW = 2 * W_FIX;

  logic signed [PW-1:0] prod_full;
  logic signed [PW-1:0] prod_shift;
  logic        [W_FIX:0] sum_wide;
  fix_t                  prod_sat;
  logic                  prod_ovf;
  logic                  add_ovf;

  always_comb begin
    prod_full  = $signed({{W_FIX{x_i[W_FIX-1]}}, x_i}) * $signed({{W_FIX{w_i[W_FIX-1]}}, w_i});
    prod_shift = prod_full >>> FRAC;
    // Product fits only if every bit above the new sign bit replicates it.
    prod_ovf   = !((&prod_shift[PW-1:W_FIX-1]) || !(|prod_shift[PW-1:W_FIX-1]));
    if (!prod_ovf) begin
      prod_sat = prod_shift[W_FIX-1:0];
    end else if (prod_shift[PW-1]) begin
      prod_sat = FIX_MIN;
    end else begin
      prod_sat = FIX_MAX;
    end

    sum_wide = {acc_i[W_FIX-1], acc_i} + {prod_sat[W_FIX-1], prod_sat};
    add_ovf  = sum_wide[W_FIX] ^ sum_wide[W_FIX-1];
    if (!add_ovf) begin
      sum_c = sum_wide[W_FIX-1:0];
    end else if (sum_wide[W_FIX]) begin
      sum_c = FIX_MIN;
    end else begin
      sum_c = FIX_MAX;
    end

    sat_c = prod_ovf | add_ovf;
  end

endmodule

// File: rtl/neuron_sequencer.sv
// Sequences one perceptron evaluation: bias + sum(x*w), clamp to [0, 1.0].
// Optional NEURON_SEQ_BYPASS_EN adds a bypass input that returns the raw sum.
module neuron_sequencer
  import nn_pkg::*;
#(
  parameter int unsigned N_INPUTS = 8,
  parameter int unsigned W        = 48
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] bias,
`ifdef NEURON_SEQ_BYPASS_EN
  input  logic         bypass,
`endif
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] x_in,
  input  logic [W-1:0] w_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] y_out,
  output logic         busy,
  output logic         sat
);

  localparam int unsigned      CNT_W = 8;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(N_INPUTS - 1);

  nseq_state_e      state_q, state_d;
  fix_t             acc_q, acc_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  fix_t             y_out_q, y_out_d;
  logic             busy_q, busy_d;
  logic             sat_q, sat_d;
`ifdef NEURON_SEQ_BYPASS_EN
  logic             bypass_q, bypass_d;
`endif

  fix_t bias_fix, x_fix, w_fix, mac_sum;
  logic mac_sat;

  assign bias_fix = W_FIX'(bias);
  assign x_fix    = W_FIX'(x_in);
  assign w_fix    = W_FIX'(w_in);

  neuron_mac u_mac (
    .acc_i (acc_q),
    .x_i   (x_fix),
    .w_i   (w_fix),
    .sum_c (mac_sum),
    .sat_c (mac_sat)
  );

  // Next-state and registered-output logic.
  always_comb begin
    fix_t clamp_val;
    state_d     = state_q;
    acc_d       = acc_q;
    count_d     = count_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    y_out_d     = y_out_q;
    busy_d      = busy_q;
    sat_d       = sat_q;
`ifdef NEURON_SEQ_BYPASS_EN
    bypass_d    = bypass_q;
`endif

    if (acc_q[W_FIX-1]) begin
      clamp_val = '0;
    end else if (acc_q > FIX_ONE) begin
      clamp_val = FIX_ONE;
    end else begin
      clamp_val = acc_q;
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = ACCUM;
          acc_d      = bias_fix;
          count_d    = '0;
          sat_d      = 1'b0;
          busy_d     = 1'b1;
          in_ready_d = 1'b1;
`ifdef NEURON_SEQ_BYPASS_EN
          bypass_d   = bypass;
`endif
        end
      end
      ACCUM: begin
        if (in_valid && in_ready_q) begin
          acc_d   = mac_sum;
          sat_d   = sat_q | mac_sat;
          count_d = CNT_W'(count_q + 1'b1);
          if (count_q == LAST) begin
            state_d    = ACT;
            in_ready_d = 1'b0;
          end
        end
      end
      ACT: begin
        y_out_d     = clamp_val;
`ifdef NEURON_SEQ_BYPASS_EN
        if (bypass_q) y_out_d = acc_q;
`endif
        out_valid_d = 1'b1;
        state_d     = OUT;
      end
      OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          busy_d      = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      count_q     <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      y_out_q     <= '0;
      busy_q      <= 1'b0;
      sat_q       <= 1'b0;
`ifdef NEURON_SEQ_BYPASS_EN
      bypass_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      count_q     <= count_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      y_out_q     <= y_out_d;
      busy_q      <= busy_d;
      sat_q       <= sat_d;
`ifdef NEURON_SEQ_BYPASS_EN
      bypass_q    <= bypass_d;
`endif
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign y_out     = W'(y_out_q);
  assign busy      = busy_q;
  assign sat       = sat_q;

endmodule

// File: tb/tb_neuron_sequencer.sv
// Randomized self-checking bench for neuron_sequencer against an arithmetic reference model.
module tb_neuron_sequencer;
  import nn_pkg::*;

  localparam int unsigned N   = 8;
  localparam int          TMO = 200;

  localparam logic [47:0] ONE_C  = 48'h000001000000;
  localparam logic [47:0] HALF_C = 48'h000000800000;
  localparam logic [47:0] QTR_C  = 48'h000000400000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic        bypass = 1'b0;
  logic [47:0] bias = '0;
  logic [47:0] x_in = '0;
  logic [47:0] w_in = '0;
  logic        in_ready, out_valid, busy, sat;
  logic [47:0] y_out;

  int   n_vec  = 0;
  int   n_fail = 0;
  fix_t xs[N];
  fix_t ws[N];

  always #5 clk = ~clk;

  neuron_sequencer #(.N_INPUTS(N), .W(48)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .bias      (bias),
`ifdef NEURON_SEQ_BYPASS_EN
    .bypass    (bypass),
`endif
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x_in      (x_in),
    .w_in      (w_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y_out     (y_out),
    .busy      (busy),
    .sat       (sat)
  );

  task automatic check(input string tag, input logic [47:0] got, input logic [47:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Wide-integer model: exact product, floor shift, range clamps, then activation.
  function automatic void ref_eval(input fix_t b, input logic byp,
                                   output logic [47:0] y, output logic s);
    logic signed [127:0] acc, p, lo, hi, one;
    lo  = FIX_MIN;
    hi  = FIX_MAX;
    one = FIX_ONE;
    acc = b;
    s   = 1'b0;
    for (int i = 0; i < N; i++) begin
      p = xs[i];
      p = p * ws[i];
      p = p >>> FRAC;
      if (p > hi) begin p = hi; s = 1'b1; end
      else if (p < lo) begin p = lo; s = 1'b1; end
      acc = acc + p;
      if (acc > hi) begin acc = hi; s = 1'b1; end
      else if (acc < lo) begin acc = lo; s = 1'b1; end
    end
    if (byp)            y = 48'(acc);
    else if (acc < 0)   y = '0;
    else if (acc > one) y = 48'(one);
    else                y = 48'(acc);
  endfunction

  task automatic clear_pairs();
    for (int i = 0; i < N; i++) begin
      xs[i] = '0;
      ws[i] = '0;
    end
  endtask

  task automatic rand_pairs();
    for (int i = 0; i < N; i++) begin
      if ($urandom_range(0, 7) == 0) xs[i] = 48'({$urandom(), $urandom()});
      else                           xs[i] = $signed($urandom()) >>> 5;
      ws[i] = $signed($urandom()) >>> 5;
    end
  endtask

  task automatic run_eval(input string tag, input fix_t b, input logic byp,
                          input int stall, input bit noise, output logic [47:0] y_seen);
    logic [47:0] exp_y;
    logic        exp_s;
    int          idx, cyc;
    bit          hs;
    ref_eval(b, byp, exp_y, exp_s);

    @(posedge clk); #1;
    start = 1'b1; bias = b; bypass = byp;
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, ":busy_start"}, 48'(busy), 48'd1);
    check({tag, ":rdy_start"}, 48'(in_ready), 48'd1);
    check({tag, ":sat_start"}, 48'(sat), 48'd0);

    idx = 0;
    cyc = 0;
    while (idx < N && cyc < TMO) begin
      in_valid = noise ? ($urandom_range(0, 2) != 0) : 1'b1;
      x_in = in_valid ? xs[idx] : 48'({$urandom(), $urandom()});
      w_in = in_valid ? ws[idx] : 48'({$urandom(), $urandom()});
      if (noise && $urandom_range(0, 4) == 0) begin
        start = 1'b1; bias = 48'({$urandom(), $urandom()}); bypass = ~byp;
      end else begin
        start = 1'b0; bias = b; bypass = byp;
      end
      hs = in_valid && in_ready;
      @(posedge clk); #1;
      cyc++;
      if (hs) idx++;
    end
    start = 1'b0; bias = b; bypass = byp;
    check({tag, ":pairs"}, 48'(idx), 48'(N));

    in_valid = 1'b1;
    x_in = 48'({$urandom(), $urandom()});
    w_in = 48'({$urandom(), $urandom()});
    check({tag, ":ov_early"}, 48'(out_valid), 48'd0);
    check({tag, ":rdy_act"}, 48'(in_ready), 48'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check({tag, ":ov_lat"}, 48'(out_valid), 48'd1);
    check({tag, ":y"}, y_out, exp_y);
    check({tag, ":sat"}, 48'(sat), 48'(exp_s));
    check({tag, ":busy_out"}, 48'(busy), 48'd1);
    y_seen = y_out;

    out_ready = 1'b0;
    for (int k = 0; k < stall; k++) begin
      start = noise && (k == 1);
      @(posedge clk); #1;
      start = 1'b0;
      check({tag, ":ov_hold"}, 48'(out_valid), 48'd1);
      check({tag, ":y_hold"}, y_out, exp_y);
      check({tag, ":busy_hold"}, 48'(busy), 48'd1);
    end

    out_ready = 1'b1;
    start = noise;
    @(posedge clk); #1;
    out_ready = 1'b0;
    start = 1'b0;
    check({tag, ":ov_done"}, 48'(out_valid), 48'd0);
    check({tag, ":busy_done"}, 48'(busy), 48'd0);
    check({tag, ":rdy_idle"}, 48'(in_ready), 48'd0);
    check({tag, ":sat_sticky"}, 48'(sat), 48'(exp_s));
  endtask

  initial begin
    logic [47:0] y;
    clear_pairs();
    repeat (3) @(posedge clk);
    #1;
    check("rst:in_ready", 48'(in_ready), 48'd0);
    check("rst:out_valid", 48'(out_valid), 48'd0);
    check("rst:y_out", y_out, 48'd0);
    check("rst:busy", 48'(busy), 48'd0);
    check("rst:sat", 48'(sat), 48'd0);
    rst_n = 1'b1;

    clear_pairs();
    xs[0] = HALF_C; ws[0] = ONE_C; xs[1] = QTR_C; ws[1] = ONE_C;
    run_eval("mix", '0, 1'b0, 0, 1'b0, y);
    check("mix:const", y, 48'h000000C00000);

    clear_pairs();
    xs[0] = HALF_C; ws[0] = HALF_C;
    run_eval("neg", -$signed(ONE_C), 1'b0, 0, 1'b0, y);
    check("neg:const", y, 48'd0);

    clear_pairs();
    xs[0] = ONE_C; ws[0] = 48'h000002000000;
    run_eval("three", ONE_C, 1'b0, 1, 1'b0, y);
    check("three:const", y, ONE_C);

    clear_pairs();
    xs[0] = HALF_C; ws[0] = ONE_C;
    run_eval("exact", HALF_C, 1'b0, 0, 1'b0, y);
    check("exact:const", y, ONE_C);

    clear_pairs();
    xs[0] = FIX_MAX; ws[0] = FIX_MAX;
    run_eval("satmax", '0, 1'b0, 0, 1'b0, y);
    check("satmax:const", y, ONE_C);
    check("satmax:flag", 48'(sat), 48'd1);

    clear_pairs();
    xs[0] = QTR_C; ws[0] = QTR_C;
    run_eval("small", '0, 1'b0, 0, 1'b0, y);
    check("small:flag", 48'(sat), 48'd0);

    rand_pairs();
    run_eval("stall", $signed($urandom()) >>> 6, 1'b0, 5, 1'b1, y);

    // Reset mid-evaluation after three pairs, then rerun cleanly.
    rand_pairs();
    @(posedge clk); #1;
    start = 1'b1; bias = ONE_C;
    @(posedge clk); #1;
    start = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      x_in = xs[i]; w_in = ws[i];
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    check("midrst:in_ready", 48'(in_ready), 48'd0);
    check("midrst:out_valid", 48'(out_valid), 48'd0);
    check("midrst:y_out", y_out, 48'd0);
    check("midrst:busy", 48'(busy), 48'd0);
    check("midrst:sat", 48'(sat), 48'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst_n = 1'b1;
    run_eval("after_rst", $signed($urandom()) >>> 6, 1'b0, 0, 1'b0, y);

    for (int t = 0; t < 20; t++) begin
      rand_pairs();
      run_eval("rand", $signed($urandom()) >>> 6, 1'b0, $urandom_range(0, 4), 1'b1, y);
    end

`ifdef NEURON_SEQ_BYPASS_EN
    clear_pairs();
    run_eval("byp1", 48'h000002800000, 1'b1, 0, 1'b0, y);
    check("byp1:const", y, 48'h000002800000);
    run_eval("byp0", 48'h000002800000, 1'b0, 0, 1'b0, y);
    check("byp0:const", y, ONE_C);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
